// File: rtl/jk_seq_detector.sv
// Overlapping serial pattern detector for the JK flip-flop output stream.
// Prefix fallback lengths are derived from PATTERN at elaboration time.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   S0    | no useful prefix; the next bit starts a fresh attempt
//   S1    | last consumed bit equals PATTERN[3]
//   S2    | last two consumed bits equal PATTERN[3:2]
//   S3    | last three consumed bits equal PATTERN[3:1]
module jk_seq_detector #(
    parameter logic [3:0] PATTERN = 4'b1011,
    parameter int         CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          valid,
    input  logic          clear,
    output logic          match,
    output logic [CW-1:0] count,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam logic [4:0]    PAT5      = {1'b0, PATTERN};
    localparam logic [CW-1:0] COUNT_MAX = '1;

    // Longest proper suffix of PATTERN that is also a prefix of it.
    function automatic logic [1:0] overlap_len();
        logic [1:0] ov;
        logic [4:0] mask;
        ov = 2'd0;
        for (int j = 1; j < 4; j++) begin
            mask = (5'd1 << j) - 5'd1;
            if ((PAT5 & mask) == (PAT5 >> (4 - j)))
                ov = 2'(j);
        end
        return ov;
    endfunction

    // Holding prefix length k means the last k bits are PATTERN[3:4-k], so the
    // candidate history is that prefix with the new bit appended at bit 0.
    function automatic logic [2:0] next_len(input logic [1:0] k, input logic b);
        logic [4:0] cand;
        logic [4:0] mask;
        logic [2:0] len;
        cand = ((PAT5 >> (3'd4 - {1'b0, k})) << 1) | {4'b0000, b};
        len  = 3'd0;
        for (int j = 1; j <= 4; j++) begin
            mask = (5'd1 << j) - 5'd1;
            if ((int'(k) + 1 >= j) && ((cand & mask) == (PAT5 >> (4 - j))))
                len = 3'(j);
        end
        return len;
    endfunction

    localparam logic [1:0] OVERLAP = overlap_len();

    state_t        state_q, state_d;
    logic          match_q, match_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        count_d = count_q;
        len     = 3'd0;
        if (clear) begin
            state_d = S0;
            count_d = '0;
        end else if (valid) begin
            len = next_len(state_q, din);
            if (len == 3'd4) begin
                match_d = 1'b1;
                state_d = state_t'(OVERLAP);
                if (count_q != COUNT_MAX)
                    count_d = count_q + 1'b1;
            end else begin
                state_d = state_t'(len[1:0]);
            end
        end
    end

    assign match = match_q;
    assign count = count_q;
    assign state = state_q;

endmodule

// File: tb/tb_jk_seq_detector.sv
// Directed bench for jk_seq_detector: vector table for the main streams plus
// hand-written sequences for saturation, back-to-back matches and async reset.
module tb_jk_seq_detector;

    logic       clk;
    logic       rst;
    logic       din;
    logic       valid;
    logic       clear;

    logic       match_a, match_b, match_c;
    logic [7:0] count_a;
    logic [1:0] count_b;
    logic [7:0] count_c;
    logic [1:0] state_a, state_b, state_c;

    int errors = 0;
    int checks = 0;

    jk_seq_detector #(.PATTERN(4'b1011), .CW(8)) dut (
        .clk(clk), .rst(rst), .din(din), .valid(valid), .clear(clear),
        .match(match_a), .count(count_a), .state(state_a)
    );

    jk_seq_detector #(.PATTERN(4'b1011), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .valid(valid), .clear(clear),
        .match(match_b), .count(count_b), .state(state_b)
    );

    jk_seq_detector #(.PATTERN(4'b1111), .CW(8)) dut_ones (
        .clk(clk), .rst(rst), .din(din), .valid(valid), .clear(clear),
        .match(match_c), .count(count_c), .state(state_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic d;
        logic v;
        logic c;
        int   st;
        int   m;
        int   cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic d, input logic v, input logic c,
                                input int st, input int m, input int cnt);
        vec_t e;
        e.d = d; e.v = v; e.c = c; e.st = st; e.m = m; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic d, input logic v, input logic c);
        @(negedge clk);
        din   = d;
        valid = v;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int nmatch;
        logic [15:0] sat_stream;

        rst = 1'b1; din = 1'b0; valid = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", state_a, 0);
        chk("reset match", match_a, 0);
        chk("reset count", count_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset state", state_a, 0);
        chk("post-reset match", match_a, 0);
        chk("post-reset count", count_a, 0);

        // basic 1011
        add(1,1,0, 1,0,0); add(0,1,0, 2,0,0); add(1,1,0, 3,0,0); add(1,1,0, 1,1,1);
        add(0,0,0, 1,0,1);                      // match drops with valid low
        add(1,1,1, 0,0,0);                      // clear beats valid
        // overlap 1011011
        add(1,1,0, 1,0,0); add(0,1,0, 2,0,0); add(1,1,0, 3,0,0); add(1,1,0, 1,1,1);
        add(0,1,0, 2,0,1); add(1,1,0, 3,0,1); add(1,1,0, 1,1,2);
        add(0,0,1, 0,0,0);
        // valid gap inside the pattern
        add(1,1,0, 1,0,0); add(0,1,0, 2,0,0);
        add(1,0,0, 2,0,0); add(0,0,0, 2,0,0); add(1,0,0, 2,0,0);
        add(1,1,0, 3,0,0); add(1,1,0, 1,1,1);
        add(0,1,1, 0,0,0);
        // no match, exercises fallbacks
        add(1,1,0, 1,0,0); add(1,1,0, 1,0,0); add(0,1,0, 2,0,0); add(0,1,0, 0,0,0);
        add(1,1,0, 1,0,0); add(0,1,0, 2,0,0); add(1,1,0, 3,0,0); add(0,1,0, 2,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].v, tbl[i].c);
            chk($sformatf("vec%0d state", i), state_a, tbl[i].st);
            chk($sformatf("vec%0d match", i), match_a, tbl[i].m);
            chk($sformatf("vec%0d count", i), count_a, tbl[i].cnt);
        end

        // saturation on the 2-bit counter: five overlapping matches
        step(0, 0, 1);
        sat_stream = 16'b1011011011011011;
        pulses = 0;
        nmatch = 0;
        for (int i = 0; i < 16; i++) begin
            step(sat_stream[15 - i], 1'b1, 1'b0);
            if (i == 3 || i == 6 || i == 9 || i == 12 || i == 15) nmatch++;
            if (match_b) pulses++;
            chk($sformatf("sat%0d match", i), match_b,
                (i == 3 || i == 6 || i == 9 || i == 12 || i == 15) ? 1 : 0);
            chk($sformatf("sat%0d count", i), count_b, (nmatch > 3) ? 3 : nmatch);
        end
        chk("sat pulses", pulses, 5);
        chk("sat wide count", count_a, 5);
        step(1, 1, 1);
        chk("sat clear count", count_b, 0);
        chk("sat clear state", state_b, 0);
        chk("sat clear match", match_b, 0);

        // back-to-back matches with PATTERN 1111
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            chk($sformatf("ones%0d state", i), state_c, (i < 3) ? i + 1 : 3);
            chk($sformatf("ones%0d match", i), match_c, (i >= 3) ? 1 : 0);
            chk($sformatf("ones%0d count", i), count_c, (i >= 3) ? i - 2 : 0);
        end
        step(0, 1, 0);
        chk("ones break state", state_c, 0);
        chk("ones break match", match_c, 0);
        chk("ones break count", count_c, 3);

        // async reset in S3, between edges
        step(0, 0, 1);
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        chk("pre-rst state", state_a, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state", state_a, 0);
        chk("async rst match", match_a, 0);
        chk("async rst count", count_a, 0);
        step(1, 1, 1);
        chk("rst over clear state", state_a, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0);
        chk("restart s1", state_a, 1);
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("restart match", match_a, 1);
        chk("restart count", count_a, 1);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_seq_detector.md
Name: jk_seq_detector

Overview:
- Serial sequence detector that sits directly downstream of the JK flip-flop.
- Samples the flip-flop output q as a bit stream, one bit per qualified clock edge.
- Recognises a fixed 4-bit pattern, with overlapping occurrences allowed, and keeps a saturating count of matches.
- Provides the observable state-machine stage for the state-machine lab: the flip-flop produces the bits and this block consumes them.

Parameters:
- PATTERN, 4'b1011, pattern to detect; MSB is the first bit received.
- CW, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit; connected to the flip-flop q output.
- valid  input  1  when high, din is consumed on this rising edge; when low, all state holds.
- clear  input  1  synchronous clear of FSM and counter; priority over valid.
- match  output  1  registered one-cycle pulse: the pattern completed on the previous edge.
- count  output  CW  number of matches since reset or clear; saturates.
- state  output  2  current prefix length, 0..3, for debug and bench observation.

Behaviour:
- Reset:
  - rst high immediately forces state=0, match=0, count=0, independent of clk.
  - All outputs hold these values while rst stays high.
  - Reset mid-sequence discards any partial prefix; detection restarts from the next valid bit after rst falls.
- FSM states S0..S3:
  - Sk means the last k consumed bits equal the first k bits of PATTERN, and k is the longest such value below 4.
  - state outputs k.
- Transition on a rising edge with valid=1, clear=0, input bit b:
  - Form the candidate sequence: the last k bits followed by b.
  - Next length k' = the longest j ≤ 4 such that the last j candidate bits equal PATTERN[3:4-j].
  - If k'=4: match pulses, count increments, and state becomes the longest proper overlap. That overlap is the longest j<4 where the last j bits of PATTERN equal its first j bits.
  - Otherwise state becomes k'.
- Default PATTERN 1011:
  - S0: b=1 -> S1; b=0 -> S0.
  - S1: b=0 -> S2; b=1 -> S1.
  - S2: b=1 -> S3; b=0 -> S0.
  - S3: b=1 -> match, S1; b=0 -> S2.
- Fallback lengths are computed combinationally from PATTERN, so any 4-bit PATTERN is handled correctly without editing the RTL.
  - Patterns 0000 and 1111: after a match, state = 3.
- Latency:
  - match and count update on the same edge that consumes the 4th pattern bit.
  - match is high for exactly that one following cycle.
  - On back-to-back matches, match stays high on consecutive cycles. This is reachable only for 0000 and 1111.
- valid=0:
  - state and count hold.
  - match deasserts at the next edge; it never stretches.
- clear=1 on an edge:
  - state=0, count=0, match=0.
  - din is ignored even if valid=1.
- Counter saturation:
  - count stops at 2^CW-1; further matches still pulse match but do not wrap.
- Simultaneous rst and clear: rst dominates, being asynchronous.
- din is assumed stable around the rising edge. The flip-flop output changes on the same edge, so integration must provide one-edge alignment. The bench drives din on the falling edge.

Test Plan:
- rst=1 for 2 cycles, then release -> state=0, match=0, count=0 during reset and immediately after.
- valid=1, din stream 1,0,1,1 -> state sequence 1,2,3,1; match high for exactly one cycle after the 4th edge; count=1.
- Overlap: stream 1,0,1,1,0,1,1 -> two match pulses, after the 4th and 7th bits; count=2; final state=1.
- valid gaps: stream 1,0,(valid=0 for 3 cycles),1,1 -> state holds at 2 during the gap; single match after the last bit; count=1.
- Non-match and fallback: stream 1,1,0,0,1,0,1,0 -> no match; states 1,1,2,0,1,2,3,2.
- CW=2 instance, 5 matches, then clear=1 with valid=1 and din=1 -> count saturates at 3 while match still pulses 5 times; after clear, count=0 and state=0. Also assert rst mid-pattern (state=3) -> state=0 asynchronously, before the next edge.
